// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite transform block.
package sprite_pkg;

    localparam int SCALE_MAX_SHIFT = 3;
    localparam int REPW            = SCALE_MAX_SHIFT;

    typedef enum logic [2:0] {
        IDLE,
        REG_POS,
        ACTIVE,
        WAIT_POS,
        SPR_LINE,
        WAIT_DATA
    } sprite_state_t;

endpackage

// File: rtl/rom_async.sv
// Bitmap ROM with combinational read, one pixel per word.
module rom_async #(
   parameter int    WIDTH  = 4,
   parameter int    DEPTH  = 64,
   parameter int    ADDRW  = 6,
   parameter string INIT_F = ""
) (
   input  logic [ADDRW-1:0] i_addr,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_data = r_mem[i_addr];

endmodule

// File: rtl/sprite_xform.sv
// Renders one scaled/mirrored bitmap per line, fetched SX_OFFS pixels ahead of
// the beam so the registered pixel lands on the matching sx.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing to draw on this line; wait for the next line pulse
// REG_POS   | capture sprite position, scale and mirroring for the line
// ACTIVE    | decide whether sy falls inside the scaled sprite rows
// WAIT_POS  | wait for the beam to reach the fetch point, load address
// SPR_LINE  | fetch and emit one pixel per cycle
// WAIT_DATA | last pixel on screen; clear outputs afterwards
module sprite_xform
    import sprite_pkg::*;
#(
    parameter int    CORDW      = 16,
    parameter int    H_RES      = 640,
    parameter int    SX_OFFS    = 2,
    parameter string SPR_FILE   = "",
    parameter int    SPR_WIDTH  = 8,
    parameter int    SPR_HEIGHT = 8,
    parameter int    SPR_DATAW  = 4,
    parameter int    SPR_TRANS  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    input  logic [1:0]              scale,
    input  logic                    flip_h,
    input  logic                    flip_v,
    output logic [SPR_DATAW-1:0]    pix,
    output logic                    drawing
);

    localparam int DEPTH = SPR_WIDTH * SPR_HEIGHT;
    localparam int ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COLW  = (SPR_WIDTH > 1) ? $clog2(SPR_WIDTH) : 1;
    localparam int ROWW  = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;

    localparam logic [COLW-1:0]         COL_LAST = COLW'(SPR_WIDTH - 1);
    localparam logic [ROWW-1:0]         ROW_LAST = ROWW'(SPR_HEIGHT - 1);
    localparam logic [CORDW-1:0]        SPR_W_C  = CORDW'(SPR_WIDTH);
    localparam logic signed [CORDW-1:0] X_OFFS   = CORDW'(SX_OFFS);
    localparam logic signed [CORDW-1:0] X_STOP   = CORDW'(H_RES - SX_OFFS);
    localparam logic [SPR_DATAW-1:0]    TRANS_C  = SPR_DATAW'(SPR_TRANS);

    sprite_state_t r_state, w_state_next;

    logic signed [CORDW-1:0] r_sprx, r_spry, w_sprx_nxt, w_spry_nxt;
    logic [1:0]              r_scale, w_scale_nxt;
    logic                    r_flip_h, r_flip_v, w_flip_h_nxt, w_flip_v_nxt;
    logic [ADDRW-1:0]        r_addr, w_addr_nxt;
    logic [COLW-1:0]         r_col, w_col_nxt;
    logic [REPW-1:0]         r_cnt, w_cnt_nxt;
    logic [ROWW-1:0]         r_row, w_row_nxt;
    logic [SPR_DATAW-1:0]    r_pix, w_pix_nxt;
    logic                    r_drawing, w_drawing_nxt;

    logic signed [CORDW-1:0] w_dy, w_dx, w_xstart, w_hgt;
    logic [CORDW-1:0]        w_col_full;
    logic [COLW-1:0]         w_col_start, w_col_step;
    logic [ROWW-1:0]         w_row, w_row_m;
    logic [REPW-1:0]         w_rep_max, w_cnt_step;
    logic                    w_in_rows, w_at_start, w_col_ok, w_last, w_stop, w_opaque;
    logic [SPR_DATAW-1:0]    w_rom_data;

    function automatic logic [ADDRW-1:0] f_addr(input logic [ROWW-1:0] row,
                                                input logic [COLW-1:0] col,
                                                input logic            flip);
        logic [COLW-1:0] mcol;
        mcol = flip ? (COL_LAST - col) : col;
        return ADDRW'(row) * ADDRW'(SPR_WIDTH) + ADDRW'(mcol);
    endfunction

    rom_async #(
        .WIDTH  (SPR_DATAW),
        .DEPTH  (DEPTH),
        .ADDRW  (ADDRW),
        .INIT_F (SPR_FILE)
    ) spr_rom (
        .i_addr (r_addr),
        .o_data (w_rom_data)
    );

    // Geometry relative to the sprite registered at the start of the line.
    assign w_dy        = sy - r_spry;
    assign w_hgt       = CORDW'(SPR_HEIGHT << r_scale);
    assign w_in_rows   = !w_dy[CORDW-1] && (w_dy < w_hgt);
    assign w_xstart    = r_sprx - X_OFFS;
    assign w_at_start  = (sx >= w_xstart);
    assign w_dx        = sx - r_sprx + X_OFFS;
    assign w_col_full  = $unsigned(w_dx) >> r_scale;
    assign w_col_ok    = (w_col_full < SPR_W_C);
    assign w_col_start = COLW'(w_col_full);
    assign w_row       = ROWW'($unsigned(w_dy) >> r_scale);
    assign w_row_m     = r_flip_v ? (ROW_LAST - w_row) : w_row;
    assign w_rep_max   = REPW'((1 << r_scale) - 1);

    assign w_cnt_step  = (r_cnt == w_rep_max) ? '0 : r_cnt + REPW'(1);
    assign w_col_step  = (r_cnt == w_rep_max) ? r_col + COLW'(1) : r_col;
    assign w_last      = (r_col == COL_LAST) && (r_cnt == w_rep_max);
    assign w_stop      = (sx == X_STOP);
    assign w_opaque    = (w_rom_data != TRANS_C);

    always_comb begin
        w_state_next  = r_state;
        w_sprx_nxt    = r_sprx;
        w_spry_nxt    = r_spry;
        w_scale_nxt   = r_scale;
        w_flip_h_nxt  = r_flip_h;
        w_flip_v_nxt  = r_flip_v;
        w_addr_nxt    = r_addr;
        w_col_nxt     = r_col;
        w_cnt_nxt     = r_cnt;
        w_row_nxt     = r_row;
        w_pix_nxt     = r_pix;
        w_drawing_nxt = r_drawing;

        if (line) begin
            w_state_next  = REG_POS;
            w_pix_nxt     = '0;
            w_drawing_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: w_state_next = IDLE;
                REG_POS: begin
                    w_sprx_nxt   = sprx;
                    w_spry_nxt   = spry;
                    w_scale_nxt  = scale;
                    w_flip_h_nxt = flip_h;
                    w_flip_v_nxt = flip_v;
                    w_state_next = ACTIVE;
                end
                ACTIVE: w_state_next = w_in_rows ? WAIT_POS : IDLE;
                WAIT_POS: begin
                    if (w_at_start) begin
                        if (w_col_ok) begin
                            w_state_next = SPR_LINE;
                            w_row_nxt    = w_row_m;
                            w_col_nxt    = w_col_start;
                            w_cnt_nxt    = w_dx[REPW-1:0] & w_rep_max;
                            w_addr_nxt   = f_addr(w_row_m, w_col_start, r_flip_h);
                        end else begin
                            w_state_next = IDLE;
                        end
                    end
                end
                SPR_LINE: begin
                    w_pix_nxt     = w_opaque ? w_rom_data : '0;
                    w_drawing_nxt = w_opaque;
                    w_col_nxt     = w_col_step;
                    w_cnt_nxt     = w_cnt_step;
                    w_addr_nxt    = f_addr(r_row, w_col_step, r_flip_h);
                    if (w_last || w_stop) w_state_next = WAIT_DATA;
                end
                WAIT_DATA: begin
                    w_pix_nxt     = '0;
                    w_drawing_nxt = 1'b0;
                    w_state_next  = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sprx    <= '0;
            r_spry    <= '0;
            r_scale   <= '0;
            r_flip_h  <= 1'b0;
            r_flip_v  <= 1'b0;
            r_addr    <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_row     <= '0;
            r_pix     <= '0;
            r_drawing <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sprx    <= w_sprx_nxt;
            r_spry    <= w_spry_nxt;
            r_scale   <= w_scale_nxt;
            r_flip_h  <= w_flip_h_nxt;
            r_flip_v  <= w_flip_v_nxt;
            r_addr    <= w_addr_nxt;
            r_col     <= w_col_nxt;
            r_cnt     <= w_cnt_nxt;
            r_row     <= w_row_nxt;
            r_pix     <= w_pix_nxt;
            r_drawing <= w_drawing_nxt;
        end
    end

    assign pix     = r_pix;
    assign drawing = r_drawing;

endmodule

// File: tb/tb_sprite_xform.sv
// Directed bench for sprite_xform: 8x8 bitmap, rows 0..6 ramp col+1, row 7 = 15-col.
`timescale 1ns/1ps
module tb_sprite_xform;

    logic                clk = 1'b0;
    logic                rst, line;
    logic signed [15:0]  sx, sy, sprx, spry;
    logic [1:0]          scale;
    logic                flip_h, flip_v;
    logic [3:0]          pix;
    logic                drawing;

    int errors = 0;
    int checks = 0;
    int ed, ep, n;

    logic [3:0] cap_pix [0:648];
    logic       cap_drw [0:648];
    logic [3:0] rst_pre_pix, rst_post_pix;
    logic       rst_pre_drw, rst_post_drw;

    sprite_xform #(
        .CORDW      (16),
        .H_RES      (640),
        .SX_OFFS    (2),
        .SPR_FILE   (""),
        .SPR_WIDTH  (8),
        .SPR_HEIGHT (8),
        .SPR_DATAW  (4),
        .SPR_TRANS  (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .line    (line),
        .sx      (sx),
        .sy      (sy),
        .sprx    (sprx),
        .spry    (spry),
        .scale   (scale),
        .flip_h  (flip_h),
        .flip_v  (flip_v),
        .pix     (pix),
        .drawing (drawing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One raster line, sx = -5..643, line pulse in the first cycle; outputs captured mid-cycle.
    task automatic drive_line(input int sy_v, input int rst_at, input int chg_at);
        for (int x = -5; x <= 643; x++) begin
            @(posedge clk); #1;
            sx   = 16'(x);
            sy   = 16'(sy_v);
            line = (x == -5);
            if (x == chg_at) begin
                sprx   = sprx + 16'sd37;
                spry   = spry - 16'sd3;
                scale  = 2'd2;
                flip_h = ~flip_h;
                flip_v = ~flip_v;
            end
            if (x == rst_at + 2) rst = 1'b0;
            @(negedge clk);
            cap_pix[x+5] = pix;
            cap_drw[x+5] = drawing;
            if (x == rst_at) begin
                rst_pre_pix = pix;
                rst_pre_drw = drawing;
                #1 rst = 1'b1;
                #1;
                rst_post_pix = pix;
                rst_post_drw = drawing;
            end
        end
        @(posedge clk); #1;
        line = 1'b0;
    endtask

    initial begin
        rst = 1'b1; line = 1'b0; sx = '0; sy = '0;
        sprx = 16'sd100; spry = 16'sd50; scale = 2'd0; flip_h = 1'b0; flip_v = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                dut.spr_rom.r_mem[r*8+c] = (r == 7) ? 4'(15 - c) : 4'(c + 1);

        // reset state, then no line pulse: must stay idle across the sprite
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pix", 32'(pix), 32'd0);
        chk("reset drawing", 32'(drawing), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int x = 90; x < 120; x++) begin
            @(posedge clk); #1;
            sx = 16'(x); sy = 16'sd50;
            @(negedge clk);
            n += int'(drawing);
        end
        chk("idle after reset", 32'(n), 32'd0);

        // scale 1x, row 0
        drive_line(50, -1000, -1000);
        for (int x = 95; x <= 112; x++) begin
            ed = (x >= 100 && x <= 107) ? 1 : 0;
            ep = (ed != 0) ? x - 99 : 0;
            chk($sformatf("s0 drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
            chk($sformatf("s0 pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end

        // scale 2x, sy=53 -> row 1
        scale = 2'd1;
        drive_line(53, -1000, -1000);
        for (int x = 98; x <= 118; x++) begin
            ed = (x >= 100 && x <= 115) ? 1 : 0;
            ep = (ed != 0) ? ((x - 100) >> 1) + 1 : 0;
            chk($sformatf("s1 drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
            chk($sformatf("s1 pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end

        // horizontal mirror
        scale = 2'd0; flip_h = 1'b1;
        drive_line(50, -1000, -1000);
        for (int x = 98; x <= 110; x++) begin
            ed = (x >= 100 && x <= 107) ? 1 : 0;
            ep = (ed != 0) ? 108 - x : 0;
            chk($sformatf("fh pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
            chk($sformatf("fh drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
        end

        // vertical mirror: sy=50 shows row 7
        flip_h = 1'b0; flip_v = 1'b1;
        drive_line(50, -1000, -1000);
        for (int x = 98; x <= 110; x++) begin
            ed = (x >= 100 && x <= 107) ? 1 : 0;
            ep = (ed != 0) ? 115 - x : 0;
            chk($sformatf("fv pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end

        // scale 4x, last row (sy=81) and first row beyond (sy=82)
        flip_v = 1'b0; scale = 2'd2;
        drive_line(81, -1000, -1000);
        for (int x = 98; x <= 134; x++) begin
            ed = (x >= 100 && x <= 131) ? 1 : 0;
            ep = (ed != 0) ? 15 - ((x - 100) >> 2) : 0;
            chk($sformatf("s2 drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
            chk($sformatf("s2 pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end
        drive_line(82, -1000, -1000);
        n = 0;
        for (int i = 0; i <= 648; i++) n += int'(cap_drw[i]);
        chk("s2 below sprite", 32'(n), 32'd0);
        scale = 2'd0;
        drive_line(49, -1000, -1000);
        n = 0;
        for (int i = 0; i <= 648; i++) n += int'(cap_drw[i]);
        chk("s0 above sprite", 32'(n), 32'd0);

        // left clip: sprx=-3 -> column 3 first at sx=0
        sprx = -16'sd3;
        drive_line(50, -1000, -1000);
        for (int x = -5; x <= 8; x++) begin
            ed = (x >= 0 && x <= 4) ? 1 : 0;
            ep = (ed != 0) ? x + 4 : 0;
            chk($sformatf("clipL drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
            chk($sformatf("clipL pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end

        // right clip: sprx=636 -> columns 0..3 then stop
        sprx = 16'sd636;
        drive_line(50, -1000, -1000);
        for (int x = 630; x <= 643; x++) begin
            ed = (x >= 636 && x <= 639) ? 1 : 0;
            ep = (ed != 0) ? x - 635 : 0;
            chk($sformatf("clipR drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
            chk($sformatf("clipR pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end

        // transparency at column 2 of row 0
        sprx = 16'sd100;
        dut.spr_rom.r_mem[2] = 4'd0;
        drive_line(50, -1000, -1000);
        for (int x = 98; x <= 110; x++) begin
            ed = (x >= 100 && x <= 107 && x != 102) ? 1 : 0;
            ep = (ed != 0) ? x - 99 : 0;
            chk($sformatf("trans drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
            chk($sformatf("trans pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end
        dut.spr_rom.r_mem[2] = 4'd3;

        // sprite inputs changed mid-line must not affect this line
        drive_line(50, -1000, 50);
        for (int x = 98; x <= 110; x++) begin
            ed = (x >= 100 && x <= 107) ? 1 : 0;
            ep = (ed != 0) ? x - 99 : 0;
            chk($sformatf("midchg pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end
        sprx = 16'sd100; spry = 16'sd50; scale = 2'd0; flip_h = 1'b0; flip_v = 1'b0;

        // async reset at sx=104 mid-sprite
        drive_line(50, 104, -1000);
        chk("rst pre pix", 32'(rst_pre_pix), 32'd5);
        chk("rst pre drw", 32'(rst_pre_drw), 32'd1);
        chk("rst post pix", 32'(rst_post_pix), 32'd0);
        chk("rst post drw", 32'(rst_post_drw), 32'd0);
        n = 0;
        for (int x = 105; x <= 643; x++) n += int'(cap_drw[x+5]) + int'(cap_pix[x+5]);
        chk("idle after mid-line rst", 32'(n), 32'd0);

        // next line after reset draws normally
        drive_line(50, -1000, -1000);
        for (int x = 98; x <= 110; x++) begin
            ed = (x >= 100 && x <= 107) ? 1 : 0;
            ep = (ed != 0) ? x - 99 : 0;
            chk($sformatf("post-rst drw sx=%0d", x), 32'(cap_drw[x+5]), 32'(ed));
            chk($sformatf("post-rst pix sx=%0d", x), 32'(cap_pix[x+5]), 32'(ep));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
